// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control path and its counter/display blocks.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_t;

    localparam int TICK_DIV_DEFAULT = 100;
    localparam int PRESC_W          = 12;

    function automatic logic is_counting(sw_state_t s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer plus rising-edge detector for one debounced button level.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic ev
);

    logic sync1, sync2, prev;
    logic vld1, vld2, armed;

    // vld1/vld2 mark when sync2 holds a real post-reset sample; armed requires a
    // genuine low sample so a button held through reset never fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            vld1  <= 1'b0;
            vld2  <= 1'b0;
            armed <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
            vld1  <= 1'b1;
            vld2  <= vld1;
            if (vld2 && !sync2)
                armed <= 1'b1;
        end
    end

    assign ev = sync2 & ~prev & armed;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM with tick prescaler; buttons enter through btn_edge.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_stop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic       run,
    output logic       tick,
    output logic       clr,
    output logic       freeze,
    output logic [1:0] state
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic                ev_ss, ev_lap, ev_clr;
    sw_state_t           state_r, state_nxt;
    logic                clr_nxt;
    logic [PRESC_W-1:0]  presc;

    btn_edge u_edge_ss  (.clk(clk), .rst(rst), .btn(btn_start_stop), .ev(ev_ss));
    btn_edge u_edge_lap (.clk(clk), .rst(rst), .btn(btn_lap),        .ev(ev_lap));
    btn_edge u_edge_clr (.clk(clk), .rst(rst), .btn(btn_clear),      .ev(ev_clr));

    // Priority clr > ss > lap, but an event only wins if it is legal in the state.
    always_comb begin
        state_nxt = state_r;
        clr_nxt   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ev_clr)
                    clr_nxt = 1'b1;
                else if (ev_ss)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (ev_ss)
                    state_nxt = ST_PAUSE;
                else if (ev_lap)
                    state_nxt = ST_LAP;
            end
            ST_LAP: begin
                if (ev_ss)
                    state_nxt = ST_PAUSE;
                else if (ev_lap)
                    state_nxt = ST_RUN;
            end
            ST_PAUSE: begin
                if (ev_clr) begin
                    state_nxt = ST_IDLE;
                    clr_nxt   = 1'b1;
                end else if (ev_ss) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            run     <= 1'b0;
            freeze  <= 1'b0;
            clr     <= 1'b0;
        end else begin
            state_r <= state_nxt;
            run     <= is_counting(state_nxt);
            freeze  <= (state_nxt == ST_LAP);
            clr     <= clr_nxt;
        end
    end

    // Prescaler advances on the registered run level, so the first tick lands
    // TICK_DIV cycles after run rises and PAUSE keeps the sub-tick residue.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clr_nxt || state_r == ST_IDLE) begin
                presc <= '0;
            end else if (run) begin
                if (presc == PRESC_LAST) begin
                    presc <= '0;
                    tick  <= 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    assign state = state_r;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100: clk cycles per count tick, legal range 2..4095.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port btn_start_stop, input, 1 bit: debounced level, asynchronous to clk.
REQ-005 SHALL have port btn_lap, input, 1 bit: debounced level, asynchronous to clk.
REQ-006 SHALL have port btn_clear, input, 1 bit: debounced level, asynchronous to clk.
REQ-007 SHALL have port run, output, 1 bit: count-enable level to the counter datapath.
REQ-008 SHALL have port tick, output, 1 bit: one-cycle increment pulse to the least-significant counter.
REQ-009 SHALL have port clr, output, 1 bit: one-cycle clear pulse to all counters.
REQ-010 SHALL have port freeze, output, 1 bit: display-hold level for lap mode.
REQ-011 SHALL have port state, output, 2 bits: current FSM state code.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer plus a rising-edge detector, giving one-cycle event pulses ev_ss, ev_lap, ev_clr.
REQ-013 SHALL make an FSM transition take effect on the 3rd rising clk edge after the first edge that samples the button high.
REQ-014 SHALL implement states IDLE=0, RUN=1, PAUSE=2, LAP=3.
REQ-015 In IDLE: ev_ss -> RUN; ev_clr -> stay IDLE and pulse clr; ev_lap ignored.
REQ-016 In RUN: ev_ss -> PAUSE; ev_lap -> LAP; ev_clr ignored.
REQ-017 In LAP: ev_lap -> RUN; ev_ss -> PAUSE; ev_clr ignored.
REQ-018 In PAUSE: ev_ss -> RUN; ev_clr -> IDLE and pulse clr; ev_lap ignored.
REQ-019 On simultaneous events, only the highest-priority event that is legal in the current state SHALL act; priority is ev_clr > ev_ss > ev_lap, and lower-priority events that cycle are discarded.
REQ-020 run SHALL be 1 exactly in RUN and LAP; freeze SHALL be 1 exactly in LAP; both are registered, not decoded glitchily.
REQ-021 The prescaler (12 bits) SHALL increment only while run=1 and wrap from TICK_DIV-1 to 0, asserting tick for that one cycle.
REQ-022 The prescaler SHALL hold its value in PAUSE (sub-tick residue preserved) and be forced to 0 in IDLE and on any clr.
REQ-023 The first tick after IDLE->RUN SHALL occur exactly TICK_DIV cycles after run rises.
REQ-024 clr SHALL be registered and assert in the same cycle the resulting state becomes visible; tick SHALL never coincide with clr.
REQ-025 A button held high SHALL generate exactly one event; re-triggering requires a low sample first.

Reset
REQ-026 While rst=1 at a clk edge: state=IDLE, run=0, tick=0, clr=0, freeze=0, prescaler=0, synchronizer and edge flops=0.
REQ-027 rst SHALL override all events in the same cycle; a button already high when rst releases SHALL NOT produce an event until it falls and rises again.
REQ-028 Reset asserted mid-RUN or mid-LAP SHALL drop run/freeze on the next edge without emitting tick or clr.

Structure
REQ-029 State codes and the default TICK_DIV SHALL live in shared package stopwatch_pkg, which the counter/display blocks also import.
REQ-030 Synchronizer plus edge detector SHALL be one sub-module, btn_edge, instantiated three times; FSM and prescaler stay in stopwatch_ctrl.

Verification (TICK_DIV=4)
REQ-031 Reset then btn_start_stop high -> state=1 on 3rd edge, run=1, tick pulses at run-rise+4, +8, +12.
REQ-032 RUN, then lap press -> state=3, freeze=1, ticks continue every 4 cycles; second lap press -> state=1, freeze=0.
REQ-033 RUN with prescaler=2, start_stop press -> PAUSE, no ticks for 50 cycles; resume -> first tick after 2 cycles.
REQ-034 PAUSE, clear+start_stop pressed together -> state=0, clr pulses once, prescaler=0; start_stop held high produces no further event.
REQ-035 RUN, clear pressed -> ignored: state stays 1, no clr; rst=1 mid-LAP -> state=0, run=freeze=tick=clr=0 next edge.
